click_decoder: RTL and testbench

- Sits directly downstream of the button debouncer.
- Consumes its one-cycle press pulses and groups presses that arrive within a timing window into a single click event: single, double or triple.
- The event is presented to the consumer (mode/menu logic) on a valid/ready handshake and held until accepted.
- Presses that arrive while an event is waiting are dropped and flagged.

---
 rtl/click_decoder.sv | 91 +++++++++
 tb/tb_click_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/click_decoder.sv
// rtl/click_decoder.sv - groups debounced press pulses into single/double/triple click events
module click_decoder #(
   parameter int WINDOW_CYCLES = 50000000,
   parameter int MAX_CLICKS    = 3,
   parameter int CNT_W         = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pulse_in,
   output logic       evt_valid,
   output logic [1:0] evt_count,
   input  logic       evt_ready,
   output logic       busy,
   output logic       overrun
);

   typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WINDOW_CYCLES - 1);
   localparam logic [1:0]       MAXC   = 2'(MAX_CLICKS);

   state_t           state;
   logic [1:0]       count;
   logic [CNT_W-1:0] timer;
   logic [1:0]       count_inc;

   assign count_inc = count + 2'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= 2'd0;
         timer     <= '0;
         evt_valid <= 1'b0;
         evt_count <= 2'd0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pulse_in) begin
                  count <= 2'd1;
                  busy  <= 1'b1;
                  if (MAXC == 2'd1) begin
                     state     <= REPORT;
                     evt_valid <= 1'b1;
                     evt_count <= 2'd1;
                  end else begin
                     state <= COLLECT;
                     timer <= RELOAD;
                  end
               end
            end
            COLLECT: begin
               // a pulse on the timer==0 edge still counts: pulse branches come first
               if (pulse_in && count_inc == MAXC) begin
                  state     <= REPORT;
                  count     <= MAXC;
                  evt_valid <= 1'b1;
                  evt_count <= MAXC;
               end else if (pulse_in) begin
                  count <= count_inc;
                  timer <= RELOAD;
               end else if (timer == '0) begin
                  state     <= REPORT;
                  evt_valid <= 1'b1;
                  evt_count <= count;
               end else begin
                  timer <= timer - CNT_W'(1);
               end
            end
            REPORT: begin
               if (pulse_in)
                  overrun <= 1'b1;
               if (evt_ready) begin
                  state     <= IDLE;
                  count     <= 2'd0;
                  evt_valid <= 1'b0;
                  evt_count <= 2'd0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_click_decoder.sv
// tb/tb_click_decoder.sv - scoreboard bench for click_decoder (WINDOW_CYCLES=8, MAX_CLICKS=3)
module tb_click_decoder;

   localparam int WIN = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pulse_in = 1'b0;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [1:0] evt_count;
   logic       busy;
   logic       overrun;

   click_decoder #(.WINDOW_CYCLES(WIN), .MAX_CLICKS(3), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .pulse_in(pulse_in),
      .evt_valid(evt_valid), .evt_count(evt_count), .evt_ready(evt_ready),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct { int cnt; int at; } exp_t;
   exp_t sb[$];

   int ecnt = 0;
   int n_cmp = 0;
   int n_bad = 0;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp_v, ecnt);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int e);
      while (ecnt < e) step();
   endtask

   // pulse is sampled by edge e
   task automatic pulse_at(input int e);
      wait_until(e - 1);
      pulse_in = 1'b1;
      step();
      pulse_in = 1'b0;
   endtask

   task automatic expect_evt(input int c, input int at);
      exp_t x;
      x.cnt = c;
      x.at  = at;
      sb.push_back(x);
   endtask

   // monitor: every rising evt_valid must match the oldest scoreboard entry
   initial begin
      logic prev = 1'b0;
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (evt_valid && !prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_evt", 1, 0);
            end else begin
               x = sb.pop_front();
               chk("evt_count", int'(evt_count), x.cnt);
               chk("evt_edge", ecnt, x.at);
            end
         end
         prev = evt_valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_outputs", int'({evt_valid, busy, overrun, evt_count}), 0);
      end

      // single click, consumer always ready
      evt_ready = 1'b1;
      b = ecnt;
      expect_evt(1, b + 10 + WIN);
      pulse_at(b + 10);
      wait_until(b + 17);
      chk("single_busy", int'(busy), 1);
      wait_until(b + 19);
      chk("single_valid_drop", int'(evt_valid), 0);
      chk("single_busy_drop", int'(busy), 0);
      wait_until(b + 40);

      // double click, held until accepted
      evt_ready = 1'b0;
      b = ecnt;
      expect_evt(2, b + 15 + WIN);
      pulse_at(b + 10);
      pulse_at(b + 15);
      wait_until(b + 29);
      chk("double_held_valid", int'(evt_valid), 1);
      chk("double_held_count", int'(evt_count), 2);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      chk("double_accept_valid", int'(evt_valid), 0);
      chk("double_accept_busy", int'(busy), 0);
      wait_until(b + 40);

      // triple click closes immediately
      evt_ready = 1'b1;
      b = ecnt;
      expect_evt(3, b + 17);
      pulse_at(b + 10);
      pulse_at(b + 14);
      pulse_at(b + 17);
      wait_until(b + 19);
      chk("triple_done_busy", int'(busy), 0);
      wait_until(b + 40);

      // second pulse one edge before timer reaches zero
      b = ecnt;
      expect_evt(2, b + 17 + WIN);
      pulse_at(b + 10);
      pulse_at(b + 17);
      wait_until(b + 40);

      // second pulse on the timer==0 edge wins over the close
      b = ecnt;
      expect_evt(2, b + 18 + WIN);
      pulse_at(b + 10);
      pulse_at(b + 18);
      wait_until(b + 40);

      // overrun while pending, pulse on the accepting edge, then reset mid-group
      evt_ready = 1'b0;
      b = ecnt;
      expect_evt(1, b + 10 + WIN);
      pulse_at(b + 10);
      wait_until(b + 19);
      chk("ovr_pre_flag", int'(overrun), 0);
      pulse_at(b + 20);
      chk("ovr_flag", int'(overrun), 1);
      chk("ovr_count", int'(evt_count), 1);
      chk("ovr_valid", int'(evt_valid), 1);
      wait_until(b + 24);
      evt_ready = 1'b1;
      pulse_in = 1'b1;
      step();
      pulse_in = 1'b0;
      evt_ready = 1'b0;
      chk("accept_pulse_valid", int'(evt_valid), 0);
      chk("accept_pulse_busy", int'(busy), 0);
      chk("accept_pulse_ovr", int'(overrun), 1);
      step();
      chk("accept_pulse_no_group", int'(busy), 0);
      pulse_at(b + 30);
      step();
      chk("new_group_busy", int'(busy), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_outputs", int'({evt_valid, busy, overrun, evt_count}), 0);
      wait_until(b + 60);
      chk("reset_no_evt", int'(busy), 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
